// File: rtl/lab1_vector_sequencer_pkg.sv
// Shared types and constants for the Lab1 vector sequencer.
// Holds state encoding, widths and the settle-count clamp helper.
package lab1_vector_sequencer_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int ERR_W   = 5;
  localparam int WCNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last wcnt value of the settle window; 0 acts as 1, >15 as 15.
  function automatic logic [WCNT_W-1:0] settle_last(input int n);
    int c;
    c = n;
    if (c < 1)  c = 1;
    if (c > 15) c = 15;
    return WCNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/lab1_vector_sequencer_if.sv
// Stimulus/response and status bundle between the sequencer
// and the three Lab1 implementations plus the observer.
interface lab1_vector_sequencer_if;
  import lab1_vector_sequencer_pkg::*;

  logic             start;
  logic             F1;
  logic             F2;
  logic             F3;
  logic             A;
  logic             B;
  logic             C;
  logic             D;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             ff_valid;
  logic [VEC_W-1:0] ff_vec;

  modport master (
    input  start,
    input  F1,
    input  F2,
    input  F3,
    output A,
    output B,
    output C,
    output D,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output ff_valid,
    output ff_vec
  );

  modport slave (
    output start,
    output F1,
    output F2,
    output F3,
    input  A,
    input  B,
    input  C,
    input  D,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  ff_valid,
    input  ff_vec
  );

endinterface

// File: rtl/lab1_vector_sequencer_cmp3.sv
// Three-way agreement check with an optional golden bit.
// Purely combinational; the sequencer samples it in CHECK.
module lab1_cmp3 (
  input  logic F1,
  input  logic F2,
  input  logic F3,
  input  logic exp_en,
  input  logic exp,
  output logic fail
);

  logic disagree;
  logic gold_bad;

  assign disagree = !(F1 == F2 && F2 == F3);
  assign gold_bad = exp_en && (F1 != exp);
  assign fail     = disagree | gold_bad;

endmodule

// File: rtl/lab1_vector_sequencer.sv
// Walks all 16 {A,B,C,D} vectors, lets them settle, and checks
// F1/F2/F3 agreement; reports pass, error count, first failure.
module lab1_vector_sequencer
  import lab1_vector_sequencer_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter bit          CHECK_GOLDEN  = 1'b0,
  parameter logic [15:0] GOLDEN        = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  lab1_vector_sequencer_if.master bus
);

  localparam logic [WCNT_W-1:0] WLAST = settle_last(SETTLE_CYCLES);

  state_t            state;
  logic [VEC_W-1:0]  vec;
  logic [WCNT_W-1:0] wcnt;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_q;
  logic              ffv_q;
  logic [VEC_W-1:0]  ffvec_q;
  logic              fail;
  logic              gold_bit;

  assign gold_bit = GOLDEN[vec];

  lab1_cmp3 u_cmp (
    .F1     (bus.F1),
    .F2     (bus.F2),
    .F3     (bus.F3),
    .exp_en (CHECK_GOLDEN),
    .exp    (gold_bit),
    .fail   (fail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vec     <= '0;
      wcnt    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            vec     <= '0;
            wcnt    <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == WLAST)
            state <= CHECK;
        end
        CHECK: begin
          if (fail)
            err_q <= err_q + 1'b1;
          if (fail && !ffv_q) begin
            ffvec_q <= vec;
            ffv_q   <= 1'b1;
          end
          // Stimulus advances on the same edge the result is taken.
          if (vec == VEC_W'(NUM_VEC - 1)) begin
            state <= DONE;
          end else begin
            vec   <= vec + 1'b1;
            wcnt  <= '0;
            state <= SETTLE;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          pass_q <= (err_q == '0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {bus.A, bus.B, bus.C, bus.D} = vec;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.ff_valid = ffv_q;
  assign bus.ff_vec   = ffvec_q;

endmodule

// File: tb/tb_lab1_vector_sequencer.sv
// Directed bench for lab1_vector_sequencer: clean, faulty and
// golden-checked runs, busy/start handling and reset mid-run.
module tb_lab1_vector_sequencer;
  import lab1_vector_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic inv3;
  logic stuck2;
  logic sel;
  logic [15:0] ref_tt  = 16'hDC7A;
  logic [3:0]  v0;
  logic [3:0]  v1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lab1_vector_sequencer_if bus0 ();
  lab1_vector_sequencer_if bus1 ();

  lab1_vector_sequencer #(
    .SETTLE_CYCLES (2),
    .CHECK_GOLDEN  (1'b0),
    .GOLDEN        (16'h0000)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  lab1_vector_sequencer #(
    .SETTLE_CYCLES (2),
    .CHECK_GOLDEN  (1'b1),
    .GOLDEN        (16'hDC72)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  assign v0 = {bus0.A, bus0.B, bus0.C, bus0.D};
  assign v1 = {bus1.A, bus1.B, bus1.C, bus1.D};

  assign bus0.F1 = ref_tt[v0];
  assign bus0.F2 = stuck2 ? 1'b1 : ref_tt[v0];
  assign bus0.F3 = (inv3 && v0 == 4'd5) ? ~ref_tt[v0] : ref_tt[v0];
  assign bus1.F1 = ref_tt[v1];
  assign bus1.F2 = ref_tt[v1];
  assign bus1.F3 = ref_tt[v1];

  logic       m_busy;
  logic       m_done;
  logic       m_pass;
  logic [4:0] m_err;
  logic       m_ffv;
  logic [3:0] m_ffvec;
  logic [3:0] m_vec;

  assign m_busy  = sel ? bus1.busy     : bus0.busy;
  assign m_done  = sel ? bus1.done     : bus0.done;
  assign m_pass  = sel ? bus1.pass     : bus0.pass;
  assign m_err   = sel ? bus1.err_cnt  : bus0.err_cnt;
  assign m_ffv   = sel ? bus1.ff_valid : bus0.ff_valid;
  assign m_ffvec = sel ? bus1.ff_vec   : bus0.ff_vec;
  assign m_vec   = sel ? v1            : v0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) bus1.start = v;
    else     bus0.start = v;
  endtask

  task automatic do_start();
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk);
    #1;
    drive_start(1'b0);
  endtask

  task automatic chk_idle0(input string tag);
    chk({tag, " vec"},   32'(v0), 32'h0);
    chk({tag, " busy"},  32'(bus0.busy), 32'h0);
    chk({tag, " done"},  32'(bus0.done), 32'h0);
    chk({tag, " pass"},  32'(bus0.pass), 32'h0);
    chk({tag, " err"},   32'(bus0.err_cnt), 32'h0);
    chk({tag, " ffv"},   32'(bus0.ff_valid), 32'h0);
    chk({tag, " ffvec"}, 32'(bus0.ff_vec), 32'h0);
  endtask

  task automatic run(input string tag, input int rk,
                     input logic [4:0] e_err, input logic e_ffv,
                     input logic [3:0] e_ffvec, input logic e_pass);
    int ev;
    do_start();
    chk({tag, " busy@0"}, 32'(m_busy), 32'h1);
    chk({tag, " vec@0"},  32'(m_vec), 32'h0);
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk);
      #1;
      drive_start(k == rk);
      ev = (k < 45) ? k / 3 : 15;
      chk($sformatf("%s vec k=%0d", tag, k),  32'(m_vec),  32'(ev));
      chk($sformatf("%s busy k=%0d", tag, k), 32'(m_busy), 32'(k < 49));
      chk($sformatf("%s done k=%0d", tag, k), 32'(m_done), 32'(k == 49));
    end
    drive_start(1'b0);
    chk({tag, " err"},   32'(m_err),   32'(e_err));
    chk({tag, " ffv"},   32'(m_ffv),   32'(e_ffv));
    chk({tag, " ffvec"}, 32'(m_ffvec), 32'(e_ffvec));
    chk({tag, " pass"},  32'(m_pass),  32'(e_pass));
    @(posedge clk);
    #1;
    chk({tag, " done_drop"}, 32'(m_done), 32'h0);
    chk({tag, " pass_hold"}, 32'(m_pass), 32'(e_pass));
    chk({tag, " vec_hold"},  32'(m_vec),  32'hF);
  endtask

  initial begin
    rst        = 1'b1;
    inv3       = 1'b0;
    stuck2     = 1'b0;
    sel        = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;

    @(posedge clk);
    #1;
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk_idle0("rst");
    chk("rst busy1", 32'(bus1.busy), 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    bus0.start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst start ignored", 32'(bus0.busy), 32'h0);

    run("clean", 0, 5'd0, 1'b0, 4'h0, 1'b1);

    inv3 = 1'b1;
    run("f3inv5", 0, 5'd1, 1'b1, 4'h5, 1'b0);
    inv3 = 1'b0;

    stuck2 = 1'b1;
    run("f2stuck", 0, 5'd6, 1'b1, 4'h0, 1'b0);
    stuck2 = 1'b0;

    run("restart", 18, 5'd0, 1'b0, 4'h0, 1'b1);

    stuck2 = 1'b1;
    do_start();
    repeat (24) @(posedge clk);
    #1;
    chk("mid vec", 32'(v0), 32'h8);
    chk("mid err", 32'(bus0.err_cnt), 32'h3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    stuck2 = 1'b0;
    chk_idle0("midrst");
    @(posedge clk);
    #1;
    chk("midrst stays idle", 32'(bus0.busy), 32'h0);
    run("fresh", 0, 5'd0, 1'b0, 4'h0, 1'b1);

    sel = 1'b1;
    run("gold1", 0, 5'd1, 1'b1, 4'h3, 1'b0);
    run("gold2", 0, 5'd1, 1'b1, 4'h3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
